ar_mem_arbiter: RTL and testbench

Sequences and shares the Action Replay cartridge memory bank (512KB: ROM at offset $00000-$3FFFF, RAM at $40000-$7FFFF) between two requesters: the CPU-side cartridge decode (selmem path) and the host loader port that uploads the cartridge ROM during bootloading. It sits between the cartridge logic and the SDRAM-side memory port. It owns the grant state machine, a host anti-starvation counter, a memory-ack timeout and ROM write protection.

---
 rtl/ar_mem_arbiter_pkg.sv | 17 +
 rtl/ar_arb_timeout.sv | 26 ++
 rtl/ar_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_ar_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ar_mem_arbiter_pkg.sv
// Shared definitions for the Action Replay cartridge memory arbiter.
// Grant state encoding, ROM/RAM split and the value returned on an aborted read.
package ar_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_HOST = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  // Word-offset bit carrying byte address bit 18: 0 = ROM half, 1 = RAM half.
  localparam int unsigned ROM_RAM_BIT = 17;

  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/ar_arb_timeout.sv
// Loadable 8-bit down-counter used to bound how long a grant waits for mem_ack.
// expired is high once the count has run down to zero.
module ar_arb_timeout (
  input  logic       clk,
  input  logic       _reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  always_comb expired = (count_q == 8'd0);

endmodule

// File: rtl/ar_mem_arbiter.sv
// Shares the Action Replay cartridge memory between the CPU decode path and the host loader.
// Define AR_ROM_WP_EN to block CPU writes to the ROM half instead of letting them patch it.
module ar_mem_arbiter
  import ar_mem_arbiter_pkg::*;
#(
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        boot,
  input  logic        cpu_req,
  input  logic [17:0] cpu_address_in,
  input  logic        cpu_rd,
  input  logic        cpu_hwr,
  input  logic        cpu_lwr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_ack,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [17:0] host_address,
  input  logic [15:0] host_data_in,
  output logic [15:0] host_data_out,
  output logic        host_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_bs,
  output logic [17:0] mem_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam logic [3:0] MaxWait = 4'(HOST_MAX_WAIT);
  localparam logic [7:0] TmoLoad = 8'(TIMEOUT - 1);

  arb_state_e  state;
  logic [3:0]  starve_cnt;
  logic        cpu_wr;
  logic        host_win;
  logic        cpu_win;
  logic        rom_wp;
  logic        in_cyc;
  logic        tmo_expired;
  logic        cyc_done;
  logic [15:0] rdata;

  always_comb begin
    cpu_wr   = !cpu_rd && (cpu_hwr || cpu_lwr);
    host_win = host_req && (boot || (starve_cnt == MaxWait) || !cpu_req);
    cpu_win  = !host_win && cpu_req && !boot;
`ifdef AR_ROM_WP_EN
    rom_wp   = cpu_wr && !cpu_address_in[ROM_RAM_BIT];
`else
    rom_wp   = 1'b0;
`endif
    in_cyc   = (state == ARB_CPU) || (state == ARB_HOST);
    // A late mem_ack on the expiry cycle still completes the access normally.
    cyc_done = mem_ack || tmo_expired;
    rdata    = mem_ack ? mem_data_in : TIMEOUT_DATA;
  end

  // Reloaded every idle cycle so it holds TIMEOUT-1 on the first cycle of a grant.
  ar_arb_timeout u_timeout (
    .clk        (clk),
    ._reset     (_reset),
    .load       (state == ARB_IDLE),
    .load_value (TmoLoad),
    .enable     (in_cyc),
    .expired    (tmo_expired)
  );

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state         <= ARB_IDLE;
      starve_cnt    <= '0;
      cpu_data_out  <= '0;
      cpu_ack       <= 1'b0;
      host_data_out <= '0;
      host_ack      <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_bs        <= '0;
      mem_address   <= '0;
      mem_data_out  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;

      if (!host_req || ((state == ARB_IDLE) && host_win)) begin
        starve_cnt <= '0;
      end else if ((state == ARB_IDLE) && cpu_win && (starve_cnt != MaxWait)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      unique case (state)
        ARB_IDLE: begin
          if (host_win) begin
            state        <= ARB_HOST;
            mem_req      <= 1'b1;
            mem_we       <= host_we;
            mem_bs       <= 2'b11;
            mem_address  <= host_address;
            mem_data_out <= host_data_in;
          end else if (cpu_win) begin
            if (rom_wp) begin
              state   <= ARB_DONE;
              cpu_ack <= 1'b1;
            end else begin
              state        <= ARB_CPU;
              mem_req      <= 1'b1;
              mem_we       <= cpu_wr;
              mem_bs       <= cpu_wr ? {cpu_hwr, cpu_lwr} : 2'b11;
              mem_address  <= cpu_address_in;
              mem_data_out <= cpu_data_in;
            end
          end
        end
        ARB_CPU, ARB_HOST: begin
          if (cyc_done) begin
            state   <= ARB_DONE;
            mem_req <= 1'b0;
            if (!mem_ack) timeout_err <= 1'b1;
            // A requester that has gone away gets no ack.
            if (state == ARB_HOST) begin
              host_ack <= host_req;
              if (host_req) host_data_out <= rdata;
            end else begin
              cpu_ack <= cpu_req;
              if (cpu_req) cpu_data_out <= rdata;
            end
          end
        end
        ARB_DONE: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ar_mem_arbiter.sv
// Self-checking bench for ar_mem_arbiter: directed scenarios plus randomized single
// transactions checked against a word-addressed memory model held in the bench.
module tb_ar_mem_arbiter;

  localparam int MaxWait = 4;
  localparam int Tmo     = 255;
`ifdef AR_ROM_WP_EN
  localparam bit WpEn = 1'b1;
`else
  localparam bit WpEn = 1'b0;
`endif

  logic        clk;
  logic        _reset;
  logic        boot;
  logic        cpu_req;
  logic [17:0] cpu_address_in;
  logic        cpu_rd;
  logic        cpu_hwr;
  logic        cpu_lwr;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;
  logic        cpu_ack;
  logic        host_req;
  logic        host_we;
  logic [17:0] host_address;
  logic [15:0] host_data_in;
  logic [15:0] host_data_out;
  logic        host_ack;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_bs;
  logic [17:0] mem_address;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;
  logic        mem_ack;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  bit terr_model = 1'b0;
  logic [15:0] mem_model [bit [17:0]];

  ar_mem_arbiter #(
    .HOST_MAX_WAIT (MaxWait),
    .TIMEOUT       (Tmo)
  ) dut (
    .clk            (clk),
    ._reset         (_reset),
    .boot           (boot),
    .cpu_req        (cpu_req),
    .cpu_address_in (cpu_address_in),
    .cpu_rd         (cpu_rd),
    .cpu_hwr        (cpu_hwr),
    .cpu_lwr        (cpu_lwr),
    .cpu_data_in    (cpu_data_in),
    .cpu_data_out   (cpu_data_out),
    .cpu_ack        (cpu_ack),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_address   (host_address),
    .host_data_in   (host_data_in),
    .host_data_out  (host_data_out),
    .host_ack       (host_ack),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_bs         (mem_bs),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .mem_ack        (mem_ack),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input bit [17:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[15:0] ^ 16'hC3C3;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_bs"}, 32'(mem_bs), 32'd0);
    check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    check({tag, "_mem_data_out"}, 32'(mem_data_out), 32'd0);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_cpu_data_out"}, 32'(cpu_data_out), 32'd0);
    check({tag, "_host_ack"}, 32'(host_ack), 32'd0);
    check({tag, "_host_data_out"}, 32'(host_data_out), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // One transaction from one requester; lat = index of the mem_req cycle that gets mem_ack.
  task automatic txn(input string tag, input bit is_host, input bit [17:0] a, input bit wr,
                     input bit [1:0] bs, input bit [15:0] wd, input int lat);
    bit          prot;
    bit          timed_out;
    int          exp_reqs;
    int          exp_ack;
    int          reqs;
    int          ack_at;
    logic [15:0] exp_rd;
    logic [15:0] got_rd;
    logic [15:0] old;
    prot      = !is_host && wr && WpEn && !a[17];
    timed_out = !prot && (lat >= Tmo);
    exp_reqs  = prot ? 0 : (timed_out ? Tmo : lat + 1);
    exp_ack   = prot ? 1 : exp_reqs + 1;
    exp_rd    = timed_out ? 16'hFFFF : model_rd(a);
    got_rd    = '0;
    @(negedge clk);
    if (is_host) begin
      host_req = 1'b1; host_we = wr; host_address = a; host_data_in = wd;
    end else begin
      cpu_req = 1'b1; cpu_address_in = a; cpu_rd = !wr;
      cpu_hwr = wr & bs[1]; cpu_lwr = wr & bs[0]; cpu_data_in = wd;
    end
    reqs   = 0;
    ack_at = 0;
    for (int n = 1; (n <= Tmo + 20) && (ack_at == 0); n++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (reqs == 0) begin
          check({tag, "_addr"}, 32'(mem_address), 32'(a));
          check({tag, "_we"}, 32'(mem_we), 32'(wr));
          check({tag, "_bs"}, 32'(mem_bs), 32'((wr && !is_host) ? bs : 2'b11));
          if (wr) check({tag, "_wdata"}, 32'(mem_data_out), 32'(wd));
        end
        if (reqs == lat) begin
          mem_ack     = 1'b1;
          mem_data_in = model_rd(a);
          if (wr) begin
            old = model_rd(a);
            mem_model[a] = {bs[1] ? wd[15:8] : old[15:8], bs[0] ? wd[7:0] : old[7:0]};
          end
        end
        reqs++;
      end
      if (is_host ? host_ack : cpu_ack) begin
        ack_at = n;
        got_rd = is_host ? host_data_out : cpu_data_out;
      end
    end
    mem_ack  = 1'b0;
    cpu_req  = 1'b0;
    host_req = 1'b0;
    if (timed_out) terr_model = 1'b1;
    check({tag, "_ack_cycle"}, 32'(ack_at), 32'(exp_ack));
    check({tag, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
    if (!wr) check({tag, "_rdata"}, 32'(got_rd), 32'(exp_rd));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(terr_model));
    @(negedge clk);
    check({tag, "_ack_single"}, 32'(is_host ? host_ack : cpu_ack), 32'd0);
  endtask

  initial begin
    int hacks;
    int cacks;
    int reqs;
    int host_at;
    bit we_seen;
    logic [17:0] addr_seen;
    logic [15:0] data_seen;

    _reset = 1'b0; boot = 1'b0;
    cpu_req = 1'b0; cpu_address_in = '0; cpu_rd = 1'b0; cpu_hwr = 1'b0; cpu_lwr = 1'b0;
    cpu_data_in = '0; host_req = 1'b0; host_we = 1'b0; host_address = '0; host_data_in = '0;
    mem_data_in = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    _reset = 1'b1;

    // CPU read of byte $40010 (word $20008), ack on second request cycle.
    mem_model[18'h20008] = 16'h1234;
    txn("cpu_rd_40010", 1'b0, 18'h20008, 1'b0, 2'b11, 16'h0, 1);

    // Boot: host write $00004 wins, CPU request is never served.
    @(negedge clk);
    boot = 1'b1;
    cpu_req = 1'b1; cpu_rd = 1'b1; cpu_hwr = 1'b0; cpu_lwr = 1'b0; cpu_address_in = 18'h20000;
    host_req = 1'b1; host_we = 1'b1; host_address = 18'h00002; host_data_in = 16'hA55A;
    hacks = 0; cacks = 0; reqs = 0; we_seen = 1'b0; addr_seen = '0; data_seen = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      mem_ack = mem_req;
      if (mem_req) begin
        reqs++; we_seen = mem_we; addr_seen = mem_address; data_seen = mem_data_out;
      end
      if (host_ack) begin hacks++; host_req = 1'b0; end
      if (cpu_ack) cacks++;
    end
    mem_ack = 1'b0; cpu_req = 1'b0; boot = 1'b0;
    mem_model[18'h00002] = 16'hA55A;
    check("boot_host_acks", 32'(hacks), 32'd1);
    check("boot_cpu_acks", 32'(cacks), 32'd0);
    check("boot_req_cycles", 32'(reqs), 32'd1);
    check("boot_we", 32'(we_seen), 32'd1);
    check("boot_addr", 32'(addr_seen), 32'h2);
    check("boot_wdata", 32'(data_seen), 32'hA55A);

    // Starvation: CPU streams, host waits exactly MaxWait CPU grants.
    @(negedge clk);
    cpu_req = 1'b1; cpu_rd = 1'b1; cpu_address_in = 18'h20010;
    host_req = 1'b1; host_we = 1'b0; host_address = 18'h20020;
    cacks = 0; host_at = -1;
    for (int n = 0; (n < 200) && (host_at < 0); n++) begin
      @(negedge clk);
      mem_ack = mem_req;
      if (cpu_ack) cacks++;
      if (host_ack) begin host_at = cacks; host_req = 1'b0; cpu_req = 1'b0; end
    end
    mem_ack = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    check("starve_cpu_grants", 32'(host_at), 32'(MaxWait));

    // Lower-byte CPU write to ROM byte $00100 (word $00080).
    txn("rom_lwr", 1'b0, 18'h00080, 1'b1, 2'b01, 16'hBEEF, 0);

    // No mem_ack at all: abort, 16'hFFFF, sticky error.
    txn("timeout", 1'b0, 18'h20100, 1'b0, 2'b11, 16'h0, 1000);

    for (int i = 0; i < 40; i++) begin
      bit          h;
      bit          w;
      bit [1:0]    b;
      h = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      b = (w && !h) ? 2'($urandom_range(1, 3)) : 2'b11;
      txn("rand", h, 18'($urandom), w, b, 16'($urandom), int'($urandom_range(0, 4)));
    end

    // Requester leaves mid-cycle: cycle completes, ack suppressed.
    @(negedge clk);
    cpu_req = 1'b1; cpu_rd = 1'b1; cpu_hwr = 1'b0; cpu_lwr = 1'b0; cpu_address_in = 18'h20030;
    cacks = 0; reqs = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (reqs == 2) mem_ack = 1'b1;
        reqs++;
      end
      if (cpu_ack) cacks++;
    end
    mem_ack = 1'b0;
    check("drop_req_cycles", 32'(reqs), 32'd3);
    check("drop_cpu_acks", 32'(cacks), 32'd0);

    // Reset during a host cycle.
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_address = 18'h20040; host_data_in = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    _reset = 1'b0;
    #1;
    check_quiet("mid_reset");
    terr_model = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    _reset = 1'b1;
    txn("post_reset_rd", 1'b0, 18'h20040, 1'b0, 2'b11, 16'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
